// File: rtl/ffs_sub255.sv
// ---------------------------------------------------------------------------
// ffs_sub255 : modular subtraction out = (a - b) mod p, p = 2^255 - 19.
//
// The 255-bit operands are processed as five 51-bit limbs, least significant
// first, one limb per clock. A SUB pass computes a - b with a registered
// borrow. A FIX pass then adds p limb by limb when that pass ended with a
// borrow, or adds zero otherwise. Both passes always run, so latency does not
// depend on the operand values.
//
// Ports
//   clk    in   1    rising-edge clock
//   rst    in   1    synchronous reset, active low
//   start  in   1    single-cycle request; accepted in IDLE and DONE only
//   a      in   255  minuend, captured on the accepting edge
//   b      in   255  subtrahend, captured on the accepting edge
//   out    out  255  registered result, valid while done = 1
//   done   out  1    registered level flag, out is valid
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start after reset
// SUB   | limb-wise a - b - borrow, 5 cycles
// FIX   | limb-wise add of p (or zero) with carry, 5 cycles
// DONE  | publish result, hold out/done until the next accepted start
// ---------------------------------------------------------------------------
module ffs_sub255 (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [254:0] a,
   input  logic [254:0] b,
   output logic [254:0] out,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Limbs of p = 2^255 - 19: the low limb is 2^51 - 19, the rest are all ones.
   localparam logic [50:0] P_LIMB_LO = 51'h7_FFFF_FFFF_FFED;
   localparam logic [50:0] P_LIMB_HI = 51'h7_FFFF_FFFF_FFFF;
   localparam logic [2:0]  LIMB_LAST = 3'd4;

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           brw_q, brw_d;
   logic           corr_q, corr_d;
   logic [254:0]   a_q, a_d;
   logic [254:0]   b_q, b_d;
   logic [254:0]   res_q, res_d;
   logic [254:0]   out_q, out_d;
   logic           done_q, done_d;

   logic [51:0]    diff;
   logic [51:0]    sum;
   logic [50:0]    p_limb;

   // Operands and result are shift registers: the current limb is always in
   // bits [50:0], and each new result limb enters at the top, so after five
   // shifts the result sits in its natural position without any limb mux.
   assign diff = {1'b0, a_q[50:0]} - {1'b0, b_q[50:0]} - {51'b0, brw_q};

   always_comb begin
      p_limb = '0;
      if (corr_q) begin
         p_limb = (cnt_q == LIMB_LAST) ? P_LIMB_LO : P_LIMB_HI;
      end
   end

   assign sum = {1'b0, res_q[50:0]} + {1'b0, p_limb} + {51'b0, brw_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      corr_d  = corr_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      out_d   = out_q;
      done_d  = done_q;

      case (state_q)
         IDLE, DONE: begin
            // First cycle in DONE publishes the finished result.
            if (state_q == DONE && !done_q) begin
               done_d = 1'b1;
               out_d  = res_q;
            end
            if (start) begin
               state_d = SUB;
               cnt_d   = LIMB_LAST;
               brw_d   = 1'b0;
               corr_d  = 1'b0;
               a_d     = a;
               b_d     = b;
               done_d  = 1'b0;
               out_d   = out_q;
            end
         end

         SUB: begin
            a_d   = {51'b0, a_q[254:51]};
            b_d   = {51'b0, b_q[254:51]};
            res_d = {diff[50:0], res_q[254:51]};
            brw_d = diff[51];
            if (cnt_q == 3'd0) begin
               // Final borrow decides whether p is added back; the same
               // register then serves as the FIX carry, starting from zero.
               state_d = FIX;
               cnt_d   = LIMB_LAST;
               corr_d  = diff[51];
               brw_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         FIX: begin
            res_d = {sum[50:0], res_q[254:51]};
            brw_d = sum[51];
            if (cnt_q == 3'd0) begin
               // Carry out of the top limb is dropped: arithmetic mod 2^255.
               state_d = DONE;
               brw_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         corr_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         corr_q  <= corr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign done = done_q;

endmodule

// File: tb/tb_ffs_sub255.sv
module tb_ffs_sub255;

   localparam logic [254:0] P = {255{1'b1}} - 255'd18;

   logic         clk;
   logic         rst;
   logic         start;
   logic [254:0] a_i;
   logic [254:0] b_i;
   logic [254:0] out_o;
   logic         done_o;

   int errors;
   int checks;

   ffs_sub255 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .out   (out_o),
      .done  (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a - b if a >= b, else a - b + p, taken mod 2^255.
   function automatic logic [254:0] model_sub(input logic [254:0] x, input logic [254:0] y);
      logic [255:0] r;
      r = {1'b0, x} - {1'b0, y};
      if (x < y) r = r + {1'b0, P};
      return r[254:0];
   endfunction

   function automatic logic [254:0] rand255(input bit reduce);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
      if (reduce && v[254:0] >= P) v[254:0] = v[254:0] - P;
      return v[254:0];
   endfunction

   // Pulses start for one cycle; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [254:0] x, input logic [254:0] y);
      @(negedge clk);
      a_i   = x;
      b_i   = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst   = 1'b0;
      start = 1'b1;
      a_i   = 255'd9;
      b_i   = 255'd3;
      repeat (3) @(negedge clk);
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got=%b exp=0", done_o);
      end
      checks++;
      if (out_o !== 255'd0) begin
         errors++;
         $display("FAIL reset_out got=%h exp=0", out_o);
      end
      // start held during reset must not launch an operation
      start = 1'b0;
      rst   = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority done got=%b exp=0", done_o);
      end
   endtask

   task automatic test_vectors;
      logic [254:0] va [8];
      logic [254:0] vb [8];
      logic [254:0] vexp [8];
      logic [254:0] exp_v;
      int lat;
      va[0] = 255'd44927731495623270119727621215091840270797887326986279676957494683529379806913;
      vb[0] = 255'd45965849458578823337785628114947185621072782472466027602082789798859530730301;
      vexp[0] = 255'd56857926655702544493727485604488608576360097187340534094603496888626413896561;
      va[1] = vb[0];
      vb[1] = va[0];
      vexp[1] = 255'd1038117962955553218058006899855345350274895145479747925125295115330150923388;
      va[2] = 255'd5;   vb[2] = 255'd7;   vexp[2] = P - 255'd2;
      va[3] = 255'd7;   vb[3] = 255'd5;   vexp[3] = 255'd2;
      va[4] = 255'd123; vb[4] = 255'd123; vexp[4] = 255'd0;
      va[5] = 255'd0;   vb[5] = P - 255'd1; vexp[5] = 255'd1;
      va[6] = P - 255'd1; vb[6] = 255'd0; vexp[6] = P - 255'd1;
      va[7] = {255{1'b1}}; vb[7] = 255'd1; vexp[7] = {255{1'b1}} - 255'd1;
      for (int i = 0; i < 8; i++) begin
         start_op(va[i], vb[i]);
         wait_done(lat);
         checks++;
         if (lat !== 11) begin
            errors++;
            $display("FAIL vec%0d_latency got=%0d exp=11", i, lat);
         end
         exp_v = model_sub(va[i], vb[i]);
         checks++;
         if (out_o !== vexp[i] || out_o !== exp_v) begin
            errors++;
            $display("FAIL vec%0d_out got=%h exp=%h", i, out_o, vexp[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [254:0] x, y, exp_v;
      int lat;
      for (int i = 0; i < 24; i++) begin
         x = rand255(i < 20);
         y = rand255(i < 20);
         if (i % 6 == 5) y = x;
         start_op(x, y);
         wait_done(lat);
         exp_v = model_sub(x, y);
         checks++;
         if (lat !== 11 || out_o !== exp_v) begin
            errors++;
            $display("FAIL rand%0d lat=%0d out=%h exp_lat=11 exp_out=%h", i, lat, out_o, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [254:0] x, y, exp_v;
      int lat;
      bit seen;
      start_op(rand255(1), rand255(1));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || out_o !== 255'd0) begin
         errors++;
         $display("FAIL reset_mid done=%b out=%h exp done=0 out=0", done_o, out_o);
      end
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_done got=%b exp=0", seen);
      end
      x = rand255(1);
      y = rand255(1);
      start_op(x, y);
      wait_done(lat);
      exp_v = model_sub(x, y);
      checks++;
      if (lat !== 11 || out_o !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_recover lat=%0d out=%h exp_lat=11 exp_out=%h", lat, out_o, exp_v);
      end
   endtask

   task automatic test_ignore_start;
      logic [254:0] x, y, exp_v;
      int lat;
      x = 255'd1000;
      y = 255'd3000;
      exp_v = model_sub(x, y);
      start_op(x, y);
      @(negedge clk);
      a_i   = 255'd77;
      b_i   = 255'd11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (!done_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 11 || out_o !== exp_v) begin
         errors++;
         $display("FAIL ignore_start lat=%0d out=%h exp_lat=11 exp_out=%h", lat, out_o, exp_v);
      end
   endtask

   task automatic test_capture;
      logic [254:0] x, y, exp_v;
      int lat;
      x = rand255(1);
      y = rand255(1);
      exp_v = model_sub(x, y);
      start_op(x, y);
      a_i = ~x;
      b_i = x;
      wait_done(lat);
      checks++;
      if (lat !== 11 || out_o !== exp_v) begin
         errors++;
         $display("FAIL capture lat=%0d out=%h exp_lat=11 exp_out=%h", lat, out_o, exp_v);
      end
   endtask

   task automatic test_back_to_back;
      logic [254:0] x, y, exp_v, held;
      int lat;
      bit changed;
      held = out_o;
      changed = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done_o !== 1'b1 || out_o !== held) changed = 1'b1;
      end
      checks++;
      if (changed !== 1'b0) begin
         errors++;
         $display("FAIL done_hold got changed=%b exp=0", changed);
      end
      x = rand255(1);
      y = rand255(1);
      exp_v = model_sub(x, y);
      start_op(x, y);
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_drop got=%b exp=0", done_o);
      end
      wait_done(lat);
      checks++;
      if (lat !== 11 || out_o !== exp_v) begin
         errors++;
         $display("FAIL b2b lat=%0d out=%h exp_lat=11 exp_out=%h", lat, out_o, exp_v);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b0;
      start  = 1'b0;
      a_i    = '0;
      b_i    = '0;
      test_reset();
      test_vectors();
      test_random();
      test_reset_mid();
      test_ignore_start();
      test_capture();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
